serial_mem_sequencer: RTL and testbench
=======================================

SERIAL_MEM_SEQUENCER -- requirements
Module: serial_mem_sequencer

Interface
REQ-001 SHALL have no parameters; the memory loop is fixed at 64 bits, organised as 8 bytes.
REQ-002 SHALL expose exactly two ports, io_in[7:0] (input) and io_out[7:0] (output), with bit fields assigned as listed below.
REQ-003 io_in[0]  input  1  clock; all flops are clocked on the rising edge.
REQ-004 io_in[1]  input  1  rst_n; asynchronous, active-low reset.
REQ-005 io_in[2]  input  1  cmd_valid; command request, sampled only in IDLE.
REQ-006 io_in[3]  input  1  cmd_we; 1 = write, 0 = read.
REQ-007 io_in[6:4]  input  3  cmd_addr; byte address 0..7.
REQ-008 io_in[7]  input  1  wdata; serial write data, LSB first.
REQ-009 io_out[0]  output  1  ready; high when state is IDLE.
REQ-010 io_out[1]  output  1  done; single-cycle pulse in the DONE state.
REQ-011 io_out[2]  output  1  rdata; serial read data, equal to the loop head bit mem[0].
REQ-012 io_out[3]  output  1  xfer; high during the 8 XFER cycles.
REQ-013 io_out[6:4]  output  3  pos[5:3]; byte index currently at the loop head.
REQ-014 io_out[7]  output  1  frame; high when pos == 0.

Function
REQ-015 SHALL hold a 64-bit loop mem[63:0] that rotates right every cycle without exception: mem <= {in_bit, mem[63:1]}.
REQ-016 in_bit SHALL equal wdata when state is XFER and the latched we is 1; otherwise in_bit SHALL equal mem[0] (recirculate).
REQ-017 SHALL keep a 6-bit position counter pos that increments by 1 every cycle and wraps from 63 to 0; pos is the logical index of mem[0].
REQ-018 Byte k SHALL occupy logical bits 8k..8k+7, LSB at 8k.
REQ-019 SHALL implement the FSM states IDLE, SEEK, XFER and DONE, decoded from registered state.
REQ-020 In IDLE, cmd_valid=1 SHALL latch cmd_addr and cmd_we and move the FSM to SEEK at that edge.
REQ-021 In SEEK, the FSM SHALL move to XFER at the edge where pos == (8*addr - 1) mod 64; addr 0 therefore exits SEEK at pos 63.
REQ-022 XFER SHALL last exactly 8 cycles, with pos = 8*addr+0 .. 8*addr+7, counted by a 3-bit bit counter that is cleared on entry.
REQ-023 For a write, wdata sampled at each XFER edge SHALL replace logical bit 8*addr+k.
REQ-024 For a read, rdata SHALL present bit 8*addr+k during XFER cycle k, and the loop content SHALL remain unchanged.
REQ-025 After the 8th XFER cycle the FSM SHALL enter DONE for one cycle, assert done, then return to IDLE.
REQ-026 SEEK latency SHALL be 1..64 cycles; total command latency from accept to done SHALL be 10..73 cycles.
REQ-027 cmd_valid SHALL be ignored in SEEK, XFER and DONE; there is no queuing and no error flag.
REQ-028 cmd_addr, cmd_we and wdata changes outside their sampling windows SHALL have no effect.
REQ-029 rdata SHALL always reflect mem[0], including in IDLE; the host qualifies it with xfer.

Reset
REQ-030 rst_n=0 SHALL immediately clear mem, pos, the bit counter, the latched addr and we, and set state to IDLE.
REQ-031 Output values under reset SHALL be: ready=1, done=0, rdata=0, xfer=0, pos[5:3]=0, frame=1.
REQ-032 Reset asserted mid-XFER SHALL abort the command with no done pulse, and the entire memory content reads 0 afterwards.
REQ-033 The first edge after rst_n deasserts SHALL advance pos from 0 to 1.

Verification
REQ-034 Reset, then 64 idle cycles -> frame pulses once every 64 cycles, pos[5:3] steps 0..7 every 8 cycles, and rdata stays 0.
REQ-035 Write 0xA5 to addr 2, driving wdata LSB first during xfer -> xfer high for exactly 8 cycles with pos[5:3]=2, then done pulses once and ready returns high.
REQ-036 Read addr 2 after that write -> rdata during xfer is 1,0,1,0,0,1,0,1; read addr 3 returns 0x00; a second read of addr 2 again returns 0xA5.
REQ-037 Write 0x3C to addr 0, accepted at pos 60 -> XFER starts when pos reaches 0 after exactly 3 SEEK cycles; a subsequent read of addr 0 returns 0x3C and addr 7 is unaffected.
REQ-038 cmd_valid held high with the opposite we throughout SEEK and XFER -> exactly one command executes; the next command is accepted in the first IDLE cycle after done.
REQ-039 rst_n pulsed low during XFER cycle 4 of a write of 0xFF to addr 5 -> outputs go to their reset values immediately, there is no done pulse, and a read of addr 5 returns 0x00.

Source files
------------

// File: rtl/serial_mem_sequencer.sv
// Serial memory sequencer: a 64-bit rotating loop. Each byte is read or written bit-serially
// as it passes the loop head.
module serial_mem_sequencer (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic [1:0] {StIdle, StSeek, StXfer, StDone} state_e;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_we;
    logic [2:0] cmd_addr;
    logic       wdata;

    assign clk       = io_in[0];
    assign rst_n     = io_in[1];
    assign cmd_valid = io_in[2];
    assign cmd_we    = io_in[3];
    assign cmd_addr  = io_in[6:4];
    assign wdata     = io_in[7];

    state_e      state_q, state_d;
    logic [63:0] mem_q;
    logic [5:0]  pos_q;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  addr_q, addr_d;
    logic        we_q, we_d;
    logic        in_bit;
    logic [5:0]  seek_target;

    // XFER must begin when pos reaches 8*addr, so SEEK exits one position earlier.
    assign seek_target = {addr_q, 3'b000} - 6'd1;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        addr_d    = addr_q;
        we_d      = we_q;
        in_bit    = mem_q[0];
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    we_d    = cmd_we;
                    state_d = StSeek;
                end
            end
            StSeek: begin
                if (pos_q == seek_target) begin
                    bit_cnt_d = 3'd0;
                    state_d   = StXfer;
                end
            end
            StXfer: begin
                if (we_q) begin
                    in_bit = wdata;
                end
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mem_q     <= 64'd0;
            pos_q     <= 6'd0;
            bit_cnt_q <= 3'd0;
            addr_q    <= 3'd0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_q     <= {in_bit, mem_q[63:1]};
            pos_q     <= pos_q + 6'd1;
            bit_cnt_q <= bit_cnt_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
        end
    end

    assign io_out[0]   = (state_q == StIdle);
    assign io_out[1]   = (state_q == StDone);
    assign io_out[2]   = mem_q[0];
    assign io_out[3]   = (state_q == StXfer);
    assign io_out[6:4] = pos_q[5:3];
    assign io_out[7]   = (pos_q == 6'd0);

endmodule

// File: tb/tb_serial_mem_sequencer.sv
// Scoreboard bench for serial_mem_sequencer: stimulus pushes expected XFER bits and done pulses,
// a negedge monitor pops and compares them.
module tb_serial_mem_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_we = 1'b0;
    logic [2:0] cmd_addr = 3'd0;
    logic       wdata = 1'b0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    assign io_in = {wdata, cmd_addr, cmd_we, cmd_valid, rst_n, clk};

    serial_mem_sequencer dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [3:0] exp_q[$];      // {pos[5:3], rdata} per XFER cycle
    int         pending_done = 0;
    logic [7:0] model[8];
    logic [5:0] tb_pos;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_pos <= 6'd0;
        else        tb_pos <= tb_pos + 6'd1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: compares every XFER cycle and done pulse against what stimulus queued.
    always @(negedge clk) begin
        if (rst_n && io_out[3]) begin
            if (exp_q.size() == 0) begin
                check("xfer_unexpected", 32'(io_out[3]), 32'd0);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                check("xfer_pos_rdata", 32'({io_out[6:4], io_out[2]}), 32'(e));
            end
        end
        if (rst_n && io_out[1]) begin
            check("done_expected", 32'(pending_done > 0), 32'd1);
            if (pending_done > 0) pending_done--;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller is at posedge+1 with ready high. hold keeps cmd_valid asserted with the opposite we.
    task automatic run_cmd(input logic we, input logic [2:0] addr, input logic [7:0] data,
                           input logic hold, output int seek_n);
        int guard;
        check("ready_before_cmd", 32'(io_out[0]), 32'd1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        for (int k = 0; k < 8; k++) exp_q.push_back({addr, model[addr][k]});
        if (we) model[addr] = data;
        pending_done++;
        tick();
        check("accepted", 32'(io_out[0]), 32'd0);
        if (hold) begin
            cmd_we   = ~we;
            cmd_addr = addr + 3'd1;
        end else begin
            cmd_valid = 1'b0;
        end
        seek_n = 0;
        guard  = 0;
        while (!io_out[3] && guard < 80) begin
            seek_n++;
            guard++;
            tick();
        end
        check("xfer_start", 32'(io_out[3]), 32'd1);
        for (int k = 0; k < 8; k++) begin
            check("xfer_len", 32'(io_out[3]), 32'd1);
            wdata = data[k];
            tick();
        end
        wdata = 1'b0;
        check("done_state", 32'({io_out[3], io_out[1], io_out[0]}), 32'b010);
        tick();
        check("ready_after", 32'(io_out[0]), 32'd1);
    endtask

    initial begin
        int sn;
        int frames;
        logic [5:0] ep;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;

        // Reset values and idle loop behaviour
        #3;
        check("reset_outputs", 32'(io_out), 32'h81);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ep = 6'd0;
        frames = 0;
        for (int c = 0; c < 64; c++) begin
            tick();
            ep = ep + 6'd1;
            if (io_out[7]) frames++;
            check("idle_outputs", 32'(io_out), 32'({ep == 6'd0, ep[5:3], 4'b0001}));
        end
        check("idle_frames", 32'(frames), 32'd1);

        // Write 0xA5 to addr 2, then read addr 2, addr 3, addr 2
        run_cmd(1'b1, 3'd2, 8'hA5, 1'b0, sn);
        check("seek_range", 32'(sn >= 1 && sn <= 64), 32'd1);
        run_cmd(1'b0, 3'd2, 8'h00, 1'b0, sn);
        run_cmd(1'b0, 3'd3, 8'h00, 1'b0, sn);
        run_cmd(1'b0, 3'd2, 8'h00, 1'b0, sn);

        // Write 0x3C to addr 0 accepted at pos 60: three SEEK cycles
        for (int g = 0; g < 70 && tb_pos != 6'd60; g++) tick();
        check("align_pos60", 32'(tb_pos), 32'd60);
        run_cmd(1'b1, 3'd0, 8'h3C, 1'b0, sn);
        check("seek_pos60_addr0", 32'(sn), 32'd3);
        run_cmd(1'b0, 3'd0, 8'h00, 1'b0, sn);
        run_cmd(1'b0, 3'd7, 8'h00, 1'b0, sn);

        // cmd_valid held through the command; next command taken in the first IDLE cycle
        run_cmd(1'b1, 3'd4, 8'h5A, 1'b1, sn);
        run_cmd(1'b0, 3'd4, 8'h00, 1'b0, sn);
        run_cmd(1'b0, 3'd2, 8'h00, 1'b0, sn);

        // Reset during XFER cycle 4 of a write of 0xFF to addr 5
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = 3'd5;
        for (int k = 0; k < 4; k++) exp_q.push_back({3'd5, model[5][k]});
        tick();
        cmd_valid = 1'b0;
        for (int g = 0; g < 80 && !io_out[3]; g++) tick();
        check("abort_xfer_start", 32'(io_out[3]), 32'd1);
        for (int k = 0; k < 4; k++) begin
            wdata = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        #1;
        check("abort_reset_outputs", 32'(io_out), 32'h81);
        wdata = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        for (int c = 0; c < 12; c++) tick();
        run_cmd(1'b0, 3'd5, 8'h00, 1'b0, sn);
        run_cmd(1'b0, 3'd2, 8'h00, 1'b0, sn);

        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("done_all_seen", 32'(pending_done), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
